latch_strobe_ctrl: RTL and testbench

Synchronous write controller that drives a bank of level-sensitive D latches (data `D`, enable `En`) from a valid/ready word stream. It holds the latch data stable, raises the enable for a programmed number of clock cycles with setup and hold margins, then reads the latch `Q` outputs back and flags any word that was not stored correctly. It sits between clocked FSM logic and gate-level latch/flip-flop storage, and is the write side of that storage.

---
 rtl/latch_strobe_ctrl.sv | 118 +++++++++++
 tb/tb_latch_strobe_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_strobe_ctrl.sv
// Write controller for a bank of level-sensitive D latches: holds data, strobes the
// enable with setup/hold margins, then reads the latches back and flags bad writes.
module latch_strobe_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] latch_d,
  output logic             latch_en,
  input  logic [WIDTH-1:0] latch_q,
  output logic             done,
  output logic             mismatch,
  output logic [7:0]       err_count,
  input  logic             clr_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       cnt_last;
  logic       check_fail;

  // A load of N expires on the Nth edge in the state, giving exactly N cycles.
  assign cnt_last   = (cnt == 8'd1);
  assign check_fail = (state == CHECK) && (latch_q != latch_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      latch_d  <= '0;
      latch_en <= 1'b0;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            latch_d  <= in_data;
            cnt      <= SETUP_LD;
            in_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_last) begin
            cnt      <= PULSE_LD;
            latch_en <= 1'b1;
            state    <= STROBE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (cnt_last) begin
            cnt      <= HOLD_LD;
            latch_en <= 1'b0;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt_last) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CHECK: begin
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          latch_en <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  // A failing readback beats a simultaneous clear, so the new error is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch  <= 1'b0;
      err_count <= 8'd0;
    end else if (check_fail) begin
      mismatch <= 1'b1;
      if (clr_err) begin
        err_count <= 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end else if (clr_err) begin
      mismatch  <= 1'b0;
      err_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_latch_strobe_ctrl.sv
// Self-checking bench for latch_strobe_ctrl: two instances (default timing and 1/1/1),
// ideal latch models with a stuck-at-0 mask, and a timeline-based reference model.
module tb_latch_strobe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] stuckMask = 8'h00;

  logic       readyA, enA, doneA, misA;
  logic [7:0] dA, qA, errA, storeA;
  logic       readyB, enB, doneB, misB;
  logic [7:0] dB, qB, errB, storeB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  latch_strobe_ctrl #(.WIDTH(8), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(readyA), .in_data(in_data),
    .latch_d(dA), .latch_en(enA), .latch_q(qA), .done(doneA), .mismatch(misA),
    .err_count(errA), .clr_err(clr_err));

  latch_strobe_ctrl #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(readyB), .in_data(in_data),
    .latch_d(dB), .latch_en(enB), .latch_q(qB), .done(doneB), .mismatch(misB),
    .err_count(errB), .clr_err(clr_err));

  // Ideal transparent latches; stuck bits read back as 0.
  always_latch if (enA) storeA <= dA;
  always_latch if (enB) storeB <= dB;
  assign qA = storeA & ~stuckMask;
  assign qB = storeB & ~stuckMask;

  typedef struct {
    int         n;
    int         acc;
    logic [7:0] d;
    bit         ready;
    bit         done;
    bit         mis;
    int         err;
  } modelT;

  modelT mA, mB;

  function automatic void modelReset(output modelT m);
    m.n = 0; m.acc = -1000; m.d = 8'h00; m.ready = 1'b1;
    m.done = 1'b0; m.mis = 1'b0; m.err = 0;
  endfunction

  // Timeline model: everything is derived from the edge number of the last accept.
  function automatic void modelStep(inout modelT m, input int s, input int p, input int h,
                                    input bit valid, input logic [7:0] data,
                                    input bit clr, input logic [7:0] stuck);
    bit wasReady;
    bit chk;
    bit fail;
    wasReady = m.ready;
    m.n = m.n + 1;
    chk = !m.ready && (m.n == m.acc + s + p + h + 1);
    m.done = chk;
    fail = chk && ((m.d & ~stuck) != m.d);
    if (chk) m.ready = 1'b1;
    if (fail) begin
      m.mis = 1'b1;
      m.err = clr ? 1 : ((m.err == 255) ? 255 : m.err + 1);
    end else if (clr) begin
      m.mis = 1'b0;
      m.err = 0;
    end
    if (wasReady && valid) begin
      m.acc = m.n; m.d = data; m.ready = 1'b0;
    end
  endfunction

  function automatic bit expEn(input modelT m, input int s, input int p);
    return !m.ready && (m.n >= m.acc + s) && (m.n < m.acc + s + p);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modelReset(mA);
      modelReset(mB);
    end else begin
      modelStep(mA, 2, 3, 2, in_valid, in_data, clr_err, stuckMask);
      modelStep(mB, 1, 1, 1, in_valid, in_data, clr_err, stuckMask);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Every output of both instances is compared against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("A.ready", {31'd0, readyA}, {31'd0, mA.ready});
    checkOutput("A.en",    {31'd0, enA},    {31'd0, expEn(mA, 2, 3)});
    checkOutput("A.d",     {24'd0, dA},     {24'd0, mA.d});
    checkOutput("A.done",  {31'd0, doneA},  {31'd0, mA.done});
    checkOutput("A.mis",   {31'd0, misA},   {31'd0, mA.mis});
    checkOutput("A.err",   {24'd0, errA},   mA.err);
    checkOutput("B.ready", {31'd0, readyB}, {31'd0, mB.ready});
    checkOutput("B.en",    {31'd0, enB},    {31'd0, expEn(mB, 1, 1)});
    checkOutput("B.d",     {24'd0, dB},     {24'd0, mB.d});
    checkOutput("B.done",  {31'd0, doneB},  {31'd0, mB.done});
    checkOutput("B.mis",   {31'd0, misB},   {31'd0, mB.mis});
    checkOutput("B.err",   {24'd0, errB},   mB.err);
  end

  task automatic waitModelA(input bit level, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (mA.ready == level) break;
    end
    if (k == limit) checkOutput("timeout", {31'd0, mA.ready}, {31'd0, level});
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    waitModelA(1'b0, 20);
    in_valid = 1'b0;
    waitModelA(1'b1, 40);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.ready", {31'd0, readyA}, 32'd1);
    checkOutput("reset.err", {24'd0, errA}, 32'd0);

    applyStimulus(8'hA5);
    checkOutput("single.mis", {31'd0, misA}, 32'd0);

    // Back-to-back words with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    waitModelA(1'b0, 20);
    in_data = 8'hC3;
    waitModelA(1'b1, 40);
    waitModelA(1'b0, 20);
    in_valid = 1'b0;
    waitModelA(1'b1, 40);
    checkOutput("b2b.mis", {31'd0, misA}, 32'd0);

    stuckMask = 8'h01;
    applyStimulus(8'hFF);
    checkOutput("stuck.mis", {31'd0, misA}, 32'd1);
    checkOutput("stuck.err1", {24'd0, errA}, 32'd1);
    applyStimulus(8'h01);
    checkOutput("stuck.err2", {24'd0, errA}, 32'd2);

    // Clear coinciding with a failing readback.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    waitModelA(1'b0, 20);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mA.n + 1 == mA.acc + 8) break;
      @(negedge clk);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checkOutput("race.mis", {31'd0, misA}, 32'd1);
    checkOutput("race.err", {24'd0, errA}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checkOutput("clr.mis", {31'd0, misA}, 32'd0);
    checkOutput("clr.err", {24'd0, errA}, 32'd0);
    stuckMask = 8'h00;

    // Asynchronous reset in the middle of the strobe.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    waitModelA(1'b0, 20);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (expEn(mA, 2, 3)) break;
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.en", {31'd0, enA}, 32'd0);
    checkOutput("rst.d", {24'd0, dA}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.ready", {31'd0, readyA}, 32'd1);
    checkOutput("rst.err", {24'd0, errA}, 32'd0);

    // Saturation: continuous failing writes well past 255 errors.
    stuckMask = 8'h01;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    repeat (2400) @(negedge clk);
    in_valid = 1'b0;
    waitModelA(1'b1, 40);
    @(negedge clk);
    checkOutput("sat.err", {24'd0, errA}, 32'd255);
    clr_err   = 1'b1;
    stuckMask = 8'h00;
    @(negedge clk);
    clr_err = 1'b0;

    // Randomized traffic with occasional clears and stuck-bit changes.
    repeat (500) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      clr_err  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0)
        stuckMask = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    end
    in_valid = 1'b0;
    clr_err  = 1'b0;
    waitModelA(1'b1, 40);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
